// File: rtl/hazard_unit_mc_pkg.sv
// Shared types and constants for the multi-cycle pipeline hazard controller.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } run_state_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Stage-register side bundle of the hazard controller: hazard inputs, stall/flush/forward outputs, counters.
interface hazard_unit_mc_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    logic          start;
    logic          branch_e;
    logic          jalr_e;
    logic          jal_d;
    logic [AW-1:0] rs1_d;
    logic [AW-1:0] rs2_d;
    logic          rs1_use_d;
    logic          rs2_use_d;
    logic [AW-1:0] rs1_e;
    logic [AW-1:0] rs2_e;
    logic          rs1_use_e;
    logic          rs2_use_e;
    logic [AW-1:0] rd_e;
    logic          load_e;
    logic          md_e;
    logic [AW-1:0] rd_m;
    logic          wr_m;
    logic [AW-1:0] rd_w;
    logic          wr_w;

    logic stall_f, stall_d, stall_e, stall_m, stall_w;
    logic flush_f, flush_d, flush_e, flush_m, flush_w;
    logic [1:0]       fwd1_e;
    logic [1:0]       fwd2_e;
    logic             md_busy;
    logic [CNT_W-1:0] cnt_load_use;
    logic [CNT_W-1:0] cnt_md_stall;
    logic [CNT_W-1:0] cnt_ctrl_flush;

    modport master (
        output start, branch_e, jalr_e, jal_d,
        output rs1_d, rs2_d, rs1_use_d, rs2_use_d,
        output rs1_e, rs2_e, rs1_use_e, rs2_use_e,
        output rd_e, load_e, md_e, rd_m, wr_m, rd_w, wr_w,
        input  stall_f, stall_d, stall_e, stall_m, stall_w,
        input  flush_f, flush_d, flush_e, flush_m, flush_w,
        input  fwd1_e, fwd2_e, md_busy,
        input  cnt_load_use, cnt_md_stall, cnt_ctrl_flush
    );

    modport slave (
        input  start, branch_e, jalr_e, jal_d,
        input  rs1_d, rs2_d, rs1_use_d, rs2_use_d,
        input  rs1_e, rs2_e, rs1_use_e, rs2_use_e,
        input  rd_e, load_e, md_e, rd_m, wr_m, rd_w, wr_w,
        output stall_f, stall_d, stall_e, stall_m, stall_w,
        output flush_f, flush_d, flush_e, flush_m, flush_w,
        output fwd1_e, fwd2_e, md_busy,
        output cnt_load_use, cnt_md_stall, cnt_ctrl_flush
    );
endinterface

// File: rtl/hazard_unit_mc_fwd_sel.sv
// Per-operand E-stage bypass select; the younger M result wins over W on a double match.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs,
    input  logic          rs_use,
    input  logic [AW-1:0] rd_m,
    input  logic          wr_m,
    input  logic [AW-1:0] rd_w,
    input  logic          wr_w,
    output logic [1:0]    sel
);

    always_comb begin
        sel = FWD_RF;
        if (wr_m && (rd_m != '0) && rs_use && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (wr_w && (rd_w != '0) && rs_use && (rd_w == rs)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage core: run gate, MUL/DIV occupancy FSM,
// load-use and control hazards, forwarding selects and saturating event counters.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int AW     = 5,
    parameter int MD_LAT = 8,
    parameter int CNT_W  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    hazard_unit_mc_if.slave hz
);

    localparam int                MDC_W   = (MD_LAT > 2) ? $clog2(MD_LAT - 1) : 1;
    localparam logic [MDC_W-1:0]  MD_INIT = MDC_W'(MD_LAT - 2);

    run_state_t       run_q, run_d;
    md_state_t        md_state_q, md_state_d;
    logic [MDC_W-1:0] md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] cnt_lu_q, cnt_lu_d;
    logic [CNT_W-1:0] cnt_md_q, cnt_md_d;
    logic [CNT_W-1:0] cnt_ctrl_q, cnt_ctrl_d;

    logic       md_stall, lu, lu_eff, ctrl, jal_flush, ctrl_flush;
    logic       stall_f, stall_d, stall_e;
    logic       flush_f, flush_d, flush_e, flush_m, flush_w;
    logic [1:0] fwd1, fwd2, fwd1_sel, fwd2_sel;

    hazard_fwd_sel #(.AW(AW)) u_fwd1 (
        .rs(hz.rs1_e), .rs_use(hz.rs1_use_e),
        .rd_m(hz.rd_m), .wr_m(hz.wr_m), .rd_w(hz.rd_w), .wr_w(hz.wr_w),
        .sel(fwd1_sel)
    );

    hazard_fwd_sel #(.AW(AW)) u_fwd2 (
        .rs(hz.rs2_e), .rs_use(hz.rs2_use_e),
        .rd_m(hz.rd_m), .wr_m(hz.wr_m), .rd_w(hz.rd_w), .wr_w(hz.wr_w),
        .sel(fwd2_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= HALT;
            md_state_q <= IDLE;
            md_cnt_q   <= '0;
            cnt_lu_q   <= '0;
            cnt_md_q   <= '0;
            cnt_ctrl_q <= '0;
        end else begin
            run_q      <= run_d;
            md_state_q <= md_state_d;
            md_cnt_q   <= md_cnt_d;
            cnt_lu_q   <= cnt_lu_d;
            cnt_md_q   <= cnt_md_d;
            cnt_ctrl_q <= cnt_ctrl_d;
        end
    end

    always_comb begin
        run_d      = hz.start ? RUN : HALT;
        md_state_d = md_state_q;
        md_cnt_d   = md_cnt_q;
        md_stall   = 1'b0;
        lu         = 1'b0;
        lu_eff     = 1'b0;
        ctrl       = 1'b0;
        jal_flush  = 1'b0;
        ctrl_flush = 1'b0;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        flush_f    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        flush_m    = 1'b0;
        flush_w    = 1'b0;
        fwd1       = FWD_RF;
        fwd2       = FWD_RF;

        if (!rst_n) begin
            flush_f = 1'b1;
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
            flush_w = 1'b1;
        end else if (run_q == HALT) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
        end else begin
            // The last occupancy cycle (BUSY with counter at zero) releases E.
            md_stall = hz.md_e && !((md_state_q == BUSY) && (md_cnt_q == '0));
            case (md_state_q)
                IDLE: begin
                    if (hz.md_e) begin
                        md_state_d = BUSY;
                        md_cnt_d   = MD_INIT;
                    end
                end
                BUSY: begin
                    if (md_cnt_q == '0) begin
                        md_state_d = IDLE;
                    end else begin
                        md_cnt_d = md_cnt_q - MDC_W'(1);
                    end
                end
            endcase

            fwd1 = fwd1_sel;
            fwd2 = fwd2_sel;

            if (md_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else begin
                lu = hz.load_e && (hz.rd_e != '0) &&
                     ((hz.rs1_use_d && (hz.rs1_d == hz.rd_e)) ||
                      (hz.rs2_use_d && (hz.rs2_d == hz.rd_e)));
                ctrl   = hz.branch_e || hz.jalr_e;
                lu_eff = lu && !ctrl;
                // A JAL held in a stalled D must survive to be redirected later.
                jal_flush  = hz.jal_d && !lu_eff;
                ctrl_flush = ctrl || jal_flush;
                stall_f    = lu_eff;
                stall_d    = lu_eff;
                flush_e    = lu_eff || ctrl;
                flush_d    = ctrl_flush;
            end
        end
    end

    always_comb begin
        cnt_lu_d   = cnt_lu_q;
        cnt_md_d   = cnt_md_q;
        cnt_ctrl_d = cnt_ctrl_q;
        if (lu_eff && (cnt_lu_q != '1)) begin
            cnt_lu_d = cnt_lu_q + CNT_W'(1);
        end
        if (md_stall && (cnt_md_q != '1)) begin
            cnt_md_d = cnt_md_q + CNT_W'(1);
        end
        if (ctrl_flush && (cnt_ctrl_q != '1)) begin
            cnt_ctrl_d = cnt_ctrl_q + CNT_W'(1);
        end
    end

    assign hz.stall_f        = stall_f;
    assign hz.stall_d        = stall_d;
    assign hz.stall_e        = stall_e;
    assign hz.stall_m        = (rst_n && (run_q == HALT));
    assign hz.stall_w        = (rst_n && (run_q == HALT));
    assign hz.flush_f        = flush_f;
    assign hz.flush_d        = flush_d;
    assign hz.flush_e        = flush_e;
    assign hz.flush_m        = flush_m;
    assign hz.flush_w        = flush_w;
    assign hz.fwd1_e         = fwd1;
    assign hz.fwd2_e         = fwd2;
    assign hz.md_busy        = (md_state_q == BUSY);
    assign hz.cnt_load_use   = cnt_lu_q;
    assign hz.cnt_md_stall   = cnt_md_q;
    assign hz.cnt_ctrl_flush = cnt_ctrl_q;

endmodule
